// File: rtl/nic2noc_vc_tracker_pkg.sv
// Shared types and default sizes for the NIC-to-NoC VC tracker.
package nic2noc_vc_tracker_pkg;

  localparam int unsigned FLIT_WIDTH_DEF = 32;
  localparam int unsigned N_OF_VC        = 3;
  localparam int unsigned N_OF_VN        = 2;

  // Per-VC lifecycle encodings
  typedef enum logic [1:0] {
    VC_IDLE     = 2'd0,
    VC_BUSY     = 2'd1,
    VC_DRAINING = 2'd2
  } vc_state_e;

endpackage

// File: rtl/nic2noc_vc_slot.sv
// One virtual channel: lifecycle FSM, owning buffer pointer and downstream credit counter.
module nic2noc_vc_slot
  import nic2noc_vc_tracker_pkg::*;
#(
  parameter int unsigned N_BITS_POINTER = 5,
  parameter int unsigned CREDIT_DEPTH   = 4,
  parameter int unsigned N_BITS_CREDIT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      grant_i,
  input  logic [N_BITS_POINTER-1:0] id_i,
  input  logic                      free_i,
  input  logic                      accept_i,
  input  logic                      tail_i,
  input  logic                      credit_i,
  output logic [N_BITS_POINTER-1:0] pointer_o,
  output logic                      active_o,
  output logic                      ready_o,
  output logic                      overflow_c_o
);

  localparam logic [N_BITS_CREDIT-1:0] CNT_FULL = N_BITS_CREDIT'(CREDIT_DEPTH);
  localparam logic [N_BITS_CREDIT-1:0] CNT_ONE  = N_BITS_CREDIT'(1);

  vc_state_e                 state_q, state_d;
  logic [N_BITS_CREDIT-1:0]  cnt_q, cnt_d;
  logic [N_BITS_POINTER-1:0] ptr_q;
  logic                      ptr_load;
  logic                      ovf_hit;

  // State and credit count register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VC_IDLE;
      cnt_q   <= CNT_FULL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pointer register; meaningless while IDLE so it carries no reset
  always_ff @(posedge clk) begin
    if (ptr_load) begin
      ptr_q <= id_i;
    end
  end

  // Next state, credit arithmetic and pointer load; free overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_load = 1'b0;
    ovf_hit  = 1'b0;

    unique case ({accept_i, credit_i})
      2'b10: cnt_d = cnt_q - CNT_ONE;
      2'b01: begin
        if (cnt_q == CNT_FULL) begin
          ovf_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = cnt_q;
    endcase

    unique case (state_q)
      VC_IDLE: begin
        if (grant_i) begin
          state_d  = VC_BUSY;
          ptr_load = 1'b1;
        end
      end
      VC_BUSY: begin
        if (accept_i && tail_i) begin
          state_d = VC_DRAINING;
        end
      end
      VC_DRAINING: begin
        if (cnt_q == CNT_FULL) begin
          state_d = VC_IDLE;
        end
      end
      default: state_d = VC_IDLE;
    endcase

    if (free_i) begin
      state_d  = VC_IDLE;
      cnt_d    = CNT_FULL;
      ptr_load = 1'b0;
    end
  end

  assign pointer_o    = ptr_q;
  assign active_o     = (state_q != VC_IDLE);
  assign ready_o      = (state_q == VC_BUSY) && (cnt_q != '0);
  assign overflow_c_o = ovf_hit;

endmodule

// File: rtl/nic2noc_vc_tracker.sv
// NIC-to-NoC output stage: per-VC tracking, credit-gated flit injection, credit forwarding.
// Optional output register stage enabled by defining NIC_OUT_REG_EN.
module nic2noc_vc_tracker
  import nic2noc_vc_tracker_pkg::*;
#(
  parameter int unsigned N_TOT_OF_VC    = N_OF_VC * N_OF_VN,
  parameter int unsigned N_BITS_POINTER = 5,
  parameter int unsigned FLIT_WIDTH     = FLIT_WIDTH_DEF,
  parameter int unsigned CREDIT_DEPTH   = 4,
  parameter int unsigned N_BITS_CREDIT  = 3,
  parameter int unsigned N_BITS_VC      = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_i,
  input  logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_i,
  input  logic [N_TOT_OF_VC-1:0]                free_signal_i,
  input  logic [FLIT_WIDTH-1:0]                 in_link_i,
  input  logic                                  is_valid_i,
  input  logic [N_BITS_VC-1:0]                  in_vc_id_i,
  input  logic                                  is_tail_i,
  output logic                                  accept_o,
  input  logic [N_TOT_OF_VC-1:0]                credit_signal_i,
  output logic [FLIT_WIDTH-1:0]                 out_link_o,
  output logic                                  is_valid_o,
  output logic [N_TOT_OF_VC-1:0]                credit_signal_o,
  output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] fifo_pointed_o,
  output logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_o,
  output logic [N_TOT_OF_VC-1:0]                vc_ready_o,
  output logic                                  credit_overflow_o
);

  logic [N_TOT_OF_VC-1:0] vc_sel;
  logic [N_TOT_OF_VC-1:0] vc_ready;
  logic [N_TOT_OF_VC-1:0] vc_active;
  logic [N_TOT_OF_VC-1:0] vc_ovf_hit;
  logic                   accept_c;
  logic                   ovf_q;

  // One-hot VC decode; ids beyond the last VC select nothing and are never accepted
  always_comb begin
    vc_sel = '0;
    for (int unsigned i = 0; i < N_TOT_OF_VC; i++) begin
      vc_sel[i] = (in_vc_id_i == N_BITS_VC'(i));
    end
  end

  assign accept_c = is_valid_i & (|(vc_sel & vc_ready));

  for (genvar g = 0; g < N_TOT_OF_VC; g++) begin : g_slot
    nic2noc_vc_slot #(
      .N_BITS_POINTER(N_BITS_POINTER),
      .CREDIT_DEPTH  (CREDIT_DEPTH),
      .N_BITS_CREDIT (N_BITS_CREDIT)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .grant_i     (g_fifo_pointer_i[g]),
      .id_i        (g_fifo_out_buffer_id_i[g*N_BITS_POINTER +: N_BITS_POINTER]),
      .free_i      (free_signal_i[g]),
      .accept_i    (accept_c & vc_sel[g]),
      .tail_i      (is_tail_i),
      .credit_i    (credit_signal_i[g]),
      .pointer_o   (fifo_pointed_o[g*N_BITS_POINTER +: N_BITS_POINTER]),
      .active_o    (vc_active[g]),
      .ready_o     (vc_ready[g]),
      .overflow_c_o(vc_ovf_hit[g])
    );
  end

  // Sticky credit overflow flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (|vc_ovf_hit) begin
      ovf_q <= 1'b1;
    end
  end

`ifdef NIC_OUT_REG_EN
  logic                  valid_q;
  logic [FLIT_WIDTH-1:0] link_q;

  // Output valid register; reset drops any in-flight flit
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept_c;
    end
  end

  // Output data register holds the last accepted flit
  always_ff @(posedge clk) begin
    if (accept_c) begin
      link_q <= in_link_i;
    end
  end

  assign out_link_o = link_q;
  assign is_valid_o = valid_q;
`else
  assign out_link_o = in_link_i;
  assign is_valid_o = accept_c;
`endif

  assign accept_o             = accept_c;
  assign vc_ready_o           = vc_ready;
  assign fifo_pointer_state_o = vc_active;
  assign credit_signal_o      = credit_signal_i & vc_active;
  assign credit_overflow_o    = ovf_q;

endmodule

// File: tb/tb_nic2noc_vc_tracker.sv
// Self-checking bench for nic2noc_vc_tracker (works with or without NIC_OUT_REG_EN).
module tb_nic2noc_vc_tracker;

  localparam int unsigned NV    = 6;
  localparam int unsigned NBP   = 5;
  localparam int unsigned FW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NBC   = 3;
  localparam int unsigned NBV   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NV-1:0]     g_fifo_pointer_i;
  logic [NV*NBP-1:0] g_fifo_out_buffer_id_i;
  logic [NV-1:0]     free_signal_i;
  logic [FW-1:0]     in_link_i;
  logic              is_valid_i;
  logic [NBV-1:0]    in_vc_id_i;
  logic              is_tail_i;
  logic              accept_o;
  logic [NV-1:0]     credit_signal_i;
  logic [FW-1:0]     out_link_o;
  logic              is_valid_o;
  logic [NV-1:0]     credit_signal_o;
  logic [NV*NBP-1:0] fifo_pointed_o;
  logic [NV-1:0]     fifo_pointer_state_o;
  logic [NV-1:0]     vc_ready_o;
  logic              credit_overflow_o;

  nic2noc_vc_tracker #(
    .N_TOT_OF_VC(NV), .N_BITS_POINTER(NBP), .FLIT_WIDTH(FW),
    .CREDIT_DEPTH(DEPTH), .N_BITS_CREDIT(NBC), .N_BITS_VC(NBV)
  ) dut (
    .clk(clk), .rst(rst),
    .g_fifo_pointer_i(g_fifo_pointer_i), .g_fifo_out_buffer_id_i(g_fifo_out_buffer_id_i),
    .free_signal_i(free_signal_i), .in_link_i(in_link_i), .is_valid_i(is_valid_i),
    .in_vc_id_i(in_vc_id_i), .is_tail_i(is_tail_i), .accept_o(accept_o),
    .credit_signal_i(credit_signal_i), .out_link_o(out_link_o), .is_valid_o(is_valid_o),
    .credit_signal_o(credit_signal_o), .fifo_pointed_o(fifo_pointed_o),
    .fifo_pointer_state_o(fifo_pointer_state_o), .vc_ready_o(vc_ready_o),
    .credit_overflow_o(credit_overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  string tag;

  // Reference model: 0 idle, 1 busy, 2 draining
  int          mst[NV];
  int          mcnt[NV];
  logic [4:0]  mptr[NV];
  logic        movf;
  logic        mprev_acc;
  logic [31:0] flq[$];

  typedef struct {
    logic [5:0] g;
    logic [4:0] gid;
    logic [5:0] fr;
    logic       v;
    logic [2:0] vc;
    logic       tl;
    logic [5:0] cr;
    logic       exp_acc;
    logic [5:0] exp_st;
  } vec_t;

  vec_t tbl[29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s]: got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] g, input logic [4:0] gid, input logic [5:0] fr,
                              input logic v, input logic [2:0] vc, input logic tl,
                              input logic [5:0] cr, input logic ea, input logic [5:0] es);
    vec_t r;
    r.g = g; r.gid = gid; r.fr = fr; r.v = v; r.vc = vc; r.tl = tl; r.cr = cr;
    r.exp_acc = ea; r.exp_st = es;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      mst[i]  = 0;
      mcnt[i] = DEPTH;
    end
    movf      = 1'b0;
    mprev_acc = 1'b0;
    flq.delete();
  endtask

  // Drive one cycle, check all outputs against the model, then advance the model
  task automatic step(input logic [5:0] g, input logic [4:0] gid, input logic [5:0] fr,
                      input logic v, input logic [2:0] vc, input logic tl, input logic [5:0] cr,
                      input logic r, input logic [31:0] fl,
                      output logic acc_a, output logic [5:0] st_a);
    logic [NV-1:0] rdy, act;
    logic          macc;
    logic [31:0]   front;
    rst = r; g_fifo_pointer_i = g; g_fifo_out_buffer_id_i = {6{gid}}; free_signal_i = fr;
    is_valid_i = v; in_vc_id_i = vc; is_tail_i = tl; credit_signal_i = cr; in_link_i = fl;
    @(negedge clk);
    macc = 1'b0;
    for (int i = 0; i < NV; i++) begin
      rdy[i] = (mst[i] == 1) && (mcnt[i] > 0);
      act[i] = (mst[i] != 0);
      if (v && (int'(vc) == i) && rdy[i]) macc = 1'b1;
    end
    chk("accept", 32'(accept_o), 32'(macc));
    chk("vc_ready", 32'(vc_ready_o), 32'(rdy));
    chk("state", 32'(fifo_pointer_state_o), 32'(act));
    chk("credit_out", 32'(credit_signal_o), 32'(cr & act));
    chk("overflow", 32'(credit_overflow_o), 32'(movf));
    for (int i = 0; i < NV; i++) begin
      if (act[i]) chk("pointer", 32'(fifo_pointed_o[i*NBP +: NBP]), 32'(mptr[i]));
    end
`ifdef NIC_OUT_REG_EN
    chk("valid_out", 32'(is_valid_o), 32'(mprev_acc));
    if (is_valid_o) begin
      if (flq.size() == 0) chk("flit_unexpected", 32'(1), 32'(0));
      else begin front = flq.pop_front(); chk("flit_data", out_link_o, front); end
    end
    if (macc) flq.push_back(fl);
`else
    if (macc) flq.push_back(fl);
    chk("valid_out", 32'(is_valid_o), 32'(macc));
    if (is_valid_o) begin
      if (flq.size() == 0) chk("flit_unexpected", 32'(1), 32'(0));
      else begin front = flq.pop_front(); chk("flit_data", out_link_o, front); end
    end
`endif
    acc_a = accept_o;
    st_a  = fifo_pointer_state_o;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < NV; i++) begin
        logic sel;
        int   oc;
        sel = macc && (int'(vc) == i);
        oc  = mcnt[i];
        if (cr[i] && !sel && oc == DEPTH) movf = 1'b1;
        if (fr[i]) mcnt[i] = DEPTH;
        else if (sel && !cr[i]) mcnt[i] = oc - 1;
        else if (cr[i] && !sel && oc < DEPTH) mcnt[i] = oc + 1;
        if (fr[i]) mst[i] = 0;
        else if (mst[i] == 0) begin
          if (g[i]) begin mst[i] = 1; mptr[i] = gid; end
        end else if (mst[i] == 1) begin
          if (sel && tl) mst[i] = 2;
        end else if (oc == DEPTH) mst[i] = 0;
      end
      mprev_acc = macc;
    end
    #1;
  endtask

  task automatic nop();
    logic a; logic [5:0] s;
    step('0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, a, s);
  endtask

  // Offer n flits on a VC and report how many were accepted
  task automatic burst(input logic [2:0] vc, input int n, output int got, output logic last);
    logic a; logic [5:0] s;
    got = 0;
    for (int k = 0; k < n; k++) begin
      step('0, '0, '0, 1'b1, vc, 1'b0, '0, 1'b0, 32'hB000_0000 + 32'(k), a, s);
      if (a) got++;
      last = a;
    end
  endtask

  initial begin
    logic       a;
    logic [5:0] s;
    int         got;
    logic       last;

    //            g         gid    fr        v  vc  tl cr        acc st
    tbl[0]  = mk(6'b000100, 5'd9,  6'b000000, 0, 2, 0, 6'b000000, 0, 6'b000000);
    tbl[1]  = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000000, 0, 6'b000100);
    tbl[2]  = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 0, 6'b000000, 1, 6'b000100);
    tbl[3]  = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 0, 6'b000000, 1, 6'b000100);
    tbl[4]  = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 0, 6'b000000, 1, 6'b000100);
    tbl[5]  = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 0, 6'b000000, 1, 6'b000100);
    tbl[6]  = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 0, 6'b000000, 0, 6'b000100);
    tbl[7]  = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 0, 6'b000100, 0, 6'b000100);
    tbl[8]  = mk(6'b000000, 5'd0,  6'b000000, 0, 2, 0, 6'b000100, 0, 6'b000100);
    tbl[9]  = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 1, 6'b000000, 1, 6'b000100);
    tbl[10] = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000100, 0, 6'b000100);
    tbl[11] = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000100, 0, 6'b000100);
    tbl[12] = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000100, 0, 6'b000100);
    tbl[13] = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000000, 0, 6'b000100);
    tbl[14] = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000100, 0, 6'b000000);
    tbl[15] = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000000, 0, 6'b000000);
    tbl[16] = mk(6'b000001, 5'd3,  6'b000001, 0, 0, 0, 6'b000000, 0, 6'b000000);
    tbl[17] = mk(6'b001000, 5'd7,  6'b000000, 0, 0, 0, 6'b000000, 0, 6'b000000);
    tbl[18] = mk(6'b000000, 5'd0,  6'b000000, 1, 3, 0, 6'b001000, 1, 6'b001000);
    tbl[19] = mk(6'b000000, 5'd0,  6'b000000, 1, 3, 0, 6'b000000, 1, 6'b001000);
    tbl[20] = mk(6'b000000, 5'd0,  6'b000000, 1, 3, 0, 6'b000000, 1, 6'b001000);
    tbl[21] = mk(6'b000000, 5'd0,  6'b000000, 1, 3, 0, 6'b000000, 1, 6'b001000);
    tbl[22] = mk(6'b000000, 5'd0,  6'b000000, 1, 3, 0, 6'b000000, 1, 6'b001000);
    tbl[23] = mk(6'b000000, 5'd0,  6'b000000, 1, 3, 0, 6'b000000, 0, 6'b001000);
    tbl[24] = mk(6'b000100, 5'd21, 6'b001000, 1, 6, 0, 6'b000000, 0, 6'b001000);
    tbl[25] = mk(6'b000000, 5'd0,  6'b000000, 1, 7, 0, 6'b000000, 0, 6'b000100);
    tbl[26] = mk(6'b000000, 5'd0,  6'b000000, 1, 2, 0, 6'b000000, 1, 6'b000100);
    tbl[27] = mk(6'b000100, 5'd30, 6'b000000, 1, 2, 0, 6'b000000, 1, 6'b000100);
    tbl[28] = mk(6'b000000, 5'd0,  6'b000000, 0, 0, 0, 6'b000000, 0, 6'b000100);

    // Reset
    tag = "reset";
    rst = 1'b1; g_fifo_pointer_i = '0; g_fifo_out_buffer_id_i = '0; free_signal_i = '0;
    in_link_i = '0; is_valid_i = 1'b0; in_vc_id_i = '0; is_tail_i = 1'b0; credit_signal_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(fifo_pointer_state_o), 32'(0));
    chk("rst_ready", 32'(vc_ready_o), 32'(0));
    chk("rst_valid", 32'(is_valid_o), 32'(0));
    chk("rst_ovf", 32'(credit_overflow_o), 32'(0));
    chk("rst_credit_out", 32'(credit_signal_o), 32'(0));
    @(posedge clk);
    #1;

    // Table-driven main sequence
    for (int r = 0; r < 29; r++) begin
      tag = $sformatf("row%0d", r);
      step(tbl[r].g, tbl[r].gid, tbl[r].fr, tbl[r].v, tbl[r].vc, tbl[r].tl, tbl[r].cr,
           1'b0, 32'hF000_0000 + 32'(r), a, s);
      chk("tbl_accept", 32'(a), 32'(tbl[r].exp_acc));
      chk("tbl_state", 32'(s), 32'(tbl[r].exp_st));
    end

    // Reset in the middle of a packet on VC2
    tag = "mid_rst";
    step('0, '0, '0, 1'b1, 3'd2, 1'b0, '0, 1'b1, 32'hDEAD_0001, a, s);
    chk("rst_cycle_accept", 32'(a), 32'(1));
    step('0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, a, s);
    chk("post_rst_state", 32'(s), 32'(0));
    chk("post_rst_valid", 32'(is_valid_o), 32'(0));

    // Count restored to full depth after reset
    tag = "depth_after_rst";
    step(6'b100000, 5'd17, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, a, s);
    burst(3'd5, 5, got, last);
    chk("depth_accepts", 32'(got), 32'(DEPTH));
    chk("depth_fifth_refused", 32'(last), 32'(0));

    // Free of a busy VC restores its count
    tag = "free_busy";
    step(6'b001000, 5'd2, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, a, s);
    burst(3'd3, 2, got, last);
    step('0, '0, 6'b001000, 1'b0, '0, 1'b0, '0, 1'b0, '0, a, s);
    step('0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, a, s);
    chk("free_state", 32'(s[3]), 32'(0));
    step(6'b001000, 5'd4, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, a, s);
    burst(3'd3, 5, got, last);
    chk("free_depth_accepts", 32'(got), 32'(DEPTH));
    chk("free_fifth_refused", 32'(last), 32'(0));

    nop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nic2noc_vc_tracker.md
# nic2noc_vc_tracker

Parametrised NIC-to-NoC output stage between the wishbone-slave packetiser and the router input port. Keeps, per virtual channel, the allocated output-buffer pointer, a three-state lifecycle and a downstream credit counter. Gates flit injection on credit availability, forwards returning credits to the owning output buffer, and frees each VC automatically once its tail flit has drained.

## Interface
Parameters:
- N_TOT_OF_VC, 6: total VCs (`N_OF_VC*`N_OF_VN).
- N_BITS_POINTER, 5: output-buffer id width.
- FLIT_WIDTH, `FLIT_WIDTH: flit width.
- CREDIT_DEPTH, 4: downstream buffer slots per VC, at least 1.
- N_BITS_CREDIT, 3: counter width, clog2(CREDIT_DEPTH+1).
- N_BITS_VC, 3: VC index width, clog2(N_TOT_OF_VC).

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset; synchronous, active-high.
- g_fifo_pointer_i  in  N_TOT_OF_VC  VC i granted by the VC allocator.
- g_fifo_out_buffer_id_i  in  N_TOT_OF_VC*N_BITS_POINTER  buffer id for each granted VC.
- free_signal_i  in  N_TOT_OF_VC  forced free of VC i; acts as an abort.
- in_link_i  in  FLIT_WIDTH  flit from the packetiser.
- is_valid_i  in  1  in_link_i is valid.
- in_vc_id_i  in  N_BITS_VC  target VC of the flit.
- is_tail_i  in  1  the flit is a tail flit.
- accept_o  out  1  flit accepted this cycle.
- credit_signal_i  in  N_TOT_OF_VC  credit returned by the router for VC i.
- out_link_o  out  FLIT_WIDTH  flit to the router.
- is_valid_o  out  1  out_link_o is valid.
- credit_signal_o  out  N_TOT_OF_VC  credit forwarded for VC i.
- fifo_pointed_o  out  N_TOT_OF_VC*N_BITS_POINTER  buffer id owning VC i.
- fifo_pointer_state_o  out  N_TOT_OF_VC  1 when VC i is not IDLE.
- vc_ready_o  out  N_TOT_OF_VC  VC i is BUSY and its credit count is greater than 0.
- credit_overflow_o  out  1  sticky error flag.

## Operation
- Per-VC state machine with states IDLE, BUSY and DRAINING.
  - IDLE to BUSY on g_fifo_pointer_i[i]. The pointer is loaded from the matching id slice in the same edge.
  - BUSY to DRAINING on an accepted flit for VC i with is_tail_i=1.
  - DRAINING to IDLE when the registered credit count equals CREDIT_DEPTH. This is checked from the cycle after entry, so the minimum stay in DRAINING is one cycle.
  - free_signal_i[i] forces IDLE from any state and resets the count to CREDIT_DEPTH.
- Grant rules:
  - A grant to a non-IDLE VC is ignored, and its pointer is kept.
  - Grant and free on the same VC in the same cycle: free wins.
- Accept rule: accept_o = is_valid_i & vc_ready_o[in_vc_id_i].
  - If in_vc_id_i >= N_TOT_OF_VC, the flit is not accepted.
  - A flit that is not accepted is not sent. Upstream must hold it.
- Credit counter per VC:
  - Reset value CREDIT_DEPTH.
  - Decrements by 1 on each accepted flit for that VC.
  - Increments by 1 on credit_signal_i[i].
  - Accept and credit in the same cycle leave the count unchanged.
  - An increment at CREDIT_DEPTH with no accept saturates the count and sets credit_overflow_o. The flag clears only on rst.
- credit_signal_o = credit_signal_i & fifo_pointer_state_o (combinational). Credits arriving on an IDLE VC are still counted but are not forwarded.
- fifo_pointed_o carries the registered pointers. Pointer registers have no reset; their value is don't-care while IDLE.

## Timing
- Reset values: all VCs IDLE, counts at CREDIT_DEPTH. The following outputs are 0: vc_ready_o, fifo_pointer_state_o, is_valid_o, credit_overflow_o, credit_signal_o.
- After a grant at edge N, vc_ready_o is high from cycle N+1.
- Flit latency from in_link_i to out_link_o is 1 cycle with NIC_OUT_REG_EN defined, 0 cycles without it.
- With the output register, is_valid_o is the registered value of accept_o, and out_link_o holds its last value when is_valid_o=0.
- A credit takes effect on vc_ready_o in the next cycle.
- rst asserted mid-packet: all state returns to reset values at the next edge, and any in-flight registered flit is discarded (is_valid_o=0).

## Configuration
- NIC_OUT_REG_EN defined: out_link_o and is_valid_o come from a register stage, and is_valid_o is cleared by rst.
- Not defined: out_link_o = in_link_i and is_valid_o = accept_o, both combinational.
- Accept and credit behaviour is identical in both builds.

## Structure
- NIC-defines.v holds `FLIT_WIDTH, `N_OF_VC, `N_OF_VN and the VC state encodings (VC_IDLE=2'd0, VC_BUSY=2'd1, VC_DRAINING=2'd2).
- One sub-module, nic2noc_vc_slot, is instantiated N_TOT_OF_VC times with generate. Each instance holds one VC's state, pointer and credit counter.
- The top level contains the accept decode and the output register.

## Test plan
- Reset, then grant VC2 with id 5'd9: fifo_pointer_state_o=6'b000100, fifo_pointed_o slice 2 = 9, and vc_ready_o[2]=1 one cycle later.
- Send 4 flits on VC2 with CREDIT_DEPTH=4 and no credits: accept_o=1 four times, the 5th flit is refused, and vc_ready_o[2]=0.
- Tail on VC2 at count 1, then return 3 credits: VC2 stays DRAINING until the count reaches 4, then goes IDLE.
- Credit and accept on the same VC in the same cycle: the count is unchanged. A credit on an IDLE VC: credit_overflow_o=1 and credit_signal_o=0.
- Grant and free on VC0 in the same cycle: VC0 stays IDLE. free_signal_i on BUSY VC3: IDLE next cycle and count=4.
- Assert rst during a packet with NIC_OUT_REG_EN defined: next cycle is_valid_o=0, all states IDLE, all counts 4.
